mux_rr_stream: RTL



---
 rtl/mux_rr_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel valid/ready stream mux with a registered output stage and either
// fixed-select or round-robin arbitration. Define MUX_RR_STALL_CNT_EN to add the STALL_CNT port.
module mux_rr_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_VALID,
   output logic [CHANNELS-1:0]       IN_READY,
   input  logic                      MODE,
   input  logic [SEL_W-1:0]          SEL,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [SEL_W-1:0]          OUT_CH
`ifdef MUX_RR_STALL_CNT_EN
   ,
   output logic [15:0]               STALL_CNT
`endif
);

   logic [WIDTH-1:0]      out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [SEL_W-1:0]      out_ch_q, out_ch_d;
   logic [SEL_W-1:0]      ptr_q, ptr_d;

   logic                  ld;
   logic                  cand_vld;
   logic [SEL_W-1:0]      cand;
   logic [CHANNELS-1:0]   grant_vec;
   logic                  xfer;
   logic [WIDTH-1:0]      sel_data;
   logic [2*CHANNELS-1:0] valid_rot;

   function automatic int rr_idx(input logic [SEL_W-1:0] base, input int offs);
      int idx;
      idx = int'(base) + offs;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      return idx;
   endfunction

   assign ld = !out_valid_q || OUT_READY;

   // Bit j of the rotated vector is channel (PTR + j) mod CHANNELS.
   assign valid_rot = {IN_VALID, IN_VALID} >> ptr_q;

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   always_comb begin
      cand     = '0;
      cand_vld = 1'b0;
      if (!MODE) begin
         if (int'(SEL) < CHANNELS) begin
            cand     = SEL;
            cand_vld = 1'b1;
         end
      end else begin
         // Walk backwards so the valid channel nearest PTR is written last and wins.
         for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
               cand     = SEL_W'(rr_idx(ptr_q, j));
               cand_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         grant_vec[i] = ld && cand_vld && (int'(cand) == i);
      end
   end

   assign IN_READY = grant_vec;
   assign xfer     = |(IN_VALID & grant_vec);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_vec[i]) sel_data = IN_DATA[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = sel_data;
         out_ch_d    = cand;
         out_valid_d = 1'b1;
         if (MODE) ptr_d = (int'(cand) == CHANNELS - 1) ? '0 : cand + SEL_W'(1);
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_CH    = out_ch_q;

`ifdef MUX_RR_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !OUT_READY && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign STALL_CNT = stall_cnt_q;
`endif

endmodule
